// File: rtl/tile_sequencer_if.sv
// Instruction handshake, buffer-read strobes and accumulator control flags
// shared between the tile sequencer and its surroundings.
interface tile_sequencer_if #(
    parameter int MAX_A_ROWS = 64,
    parameter int MAX_KTILES = 16
);
    localparam int AW  = $clog2(MAX_A_ROWS + 1);
    localparam int KTW = $clog2(MAX_KTILES + 1);
    localparam int KW  = (MAX_KTILES > 1) ? $clog2(MAX_KTILES) : 1;

    // inst_valid/inst_ready: an instruction transfers on a rising edge where
    // both are high; inst_ready is high only while the sequencer is idle and
    // inst_a_rows/inst_ktiles are captured on that same edge.
    logic           inst_valid;
    logic           inst_ready;
    logic [AW-1:0]  inst_a_rows;
    logic [KTW-1:0] inst_ktiles;
    logic           w_avail;
    logic           if_avail;
    logic           w_buffer_read;
    logic           if_buffer_read;
    logic           switch;
    logic           first;
    logic           last;
    logic [KW-1:0]  k_idx;
    logic           busy;
    logic           done;
    logic [2:0]     state_dbg;

    modport master (
        output inst_valid, inst_a_rows, inst_ktiles, w_avail, if_avail,
        input  inst_ready, w_buffer_read, if_buffer_read, switch, first, last,
               k_idx, busy, done, state_dbg
    );

    modport slave (
        input  inst_valid, inst_a_rows, inst_ktiles, w_avail, if_avail,
        output inst_ready, w_buffer_read, if_buffer_read, switch, first, last,
               k_idx, busy, done, state_dbg
    );
endinterface

// File: rtl/tile_sequencer.sv
// Tile sequencer: runs one GEMM instruction over K tiles. Weights for tile
// k+1 are loaded into the shadow buffer while tile k streams input rows,
// then a switch pulse swaps them in; after the last tile the array drains.
module tile_sequencer #(
    parameter int SYS_ROWS   = 8,
    parameter int SYS_COLS   = 8,
    parameter int MAX_A_ROWS = 64,
    parameter int MAX_KTILES = 16,
    parameter int DRAIN      = SYS_ROWS + SYS_COLS - 1
) (
    input logic             clk,
    input logic             rst,
    tile_sequencer_if.slave bus
);
    localparam int AW  = $clog2(MAX_A_ROWS + 1);
    localparam int KTW = $clog2(MAX_KTILES + 1);
    localparam int KW  = (MAX_KTILES > 1) ? $clog2(MAX_KTILES) : 1;
    localparam int WCW = $clog2(SYS_ROWS + 1);
    localparam int DCW = $clog2(DRAIN + 1);

    localparam logic [AW-1:0]  A_MAX  = AW'(MAX_A_ROWS);
    localparam logic [KTW-1:0] KT_MAX = KTW'(MAX_KTILES);
    localparam logic [WCW-1:0] W_FULL = WCW'(SYS_ROWS);
    localparam logic [WCW-1:0] W_LAST = WCW'(SYS_ROWS - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRELOAD, S_SWITCH, S_STREAM, S_WAIT_W, S_DRAIN, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  a_rows_q;
    logic [KTW-1:0] ktiles_q;
    logic [KW-1:0]  k_q;
    logic [WCW-1:0] wcnt_q;
    logic [AW-1:0]  acnt_q;
    logic [DCW-1:0] dcnt_q;

    logic           w_rd, if_rd, sw, fst, lst, dn;
    logic           accept, zero_len;
    logic [KTW-1:0] k_plus;
    logic           is_last_tile, more_tiles, w_full, w_fin, a_fin;

    assign accept       = bus.inst_valid && (state_q == S_IDLE);
    assign zero_len     = (bus.inst_a_rows == '0) || (bus.inst_ktiles == '0);
    assign k_plus       = KTW'(k_q) + KTW'(1);
    assign is_last_tile = (k_plus == ktiles_q);
    assign more_tiles   = (k_plus < ktiles_q);
    assign w_full       = (wcnt_q == W_FULL);
    // A weight read this cycle that completes the shadow load.
    assign w_fin        = w_rd && (wcnt_q == W_LAST);
    // An input read this cycle that completes the current tile's rows.
    assign a_fin        = if_rd && ((acnt_q + AW'(1)) == a_rows_q);

    // Next-state and Moore outputs; reads are additionally gated by avail.
    always_comb begin
        state_d = state_q;
        w_rd    = 1'b0;
        if_rd   = 1'b0;
        sw      = 1'b0;
        fst     = 1'b0;
        lst     = 1'b0;
        dn      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = zero_len ? S_DONE : S_PRELOAD;
            end
            S_PRELOAD: begin
                w_rd = bus.w_avail;
                if (w_fin) state_d = S_SWITCH;
            end
            S_SWITCH: begin
                sw      = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if_rd = bus.if_avail;
                fst   = (k_q == '0);
                lst   = is_last_tile;
                if (more_tiles && !w_full) w_rd = bus.w_avail;
                if (a_fin) begin
                    if (is_last_tile)         state_d = S_DRAIN;
                    else if (w_full || w_fin) state_d = S_SWITCH;
                    else                      state_d = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                w_rd = bus.w_avail;
                if (w_fin) state_d = S_SWITCH;
            end
            S_DRAIN: begin
                if (dcnt_q == D_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                dn      = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, instruction fields and the weight/row/tile/drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_rows_q <= '0;
            ktiles_q <= '0;
            k_q      <= '0;
            wcnt_q   <= '0;
            acnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_rows_q <= (bus.inst_a_rows > A_MAX) ? A_MAX : bus.inst_a_rows;
                        ktiles_q <= (bus.inst_ktiles > KT_MAX) ? KT_MAX : bus.inst_ktiles;
                        k_q      <= '0;
                        wcnt_q   <= '0;
                        acnt_q   <= '0;
                    end
                end
                S_SWITCH: begin
                    wcnt_q <= '0;
                    acnt_q <= '0;
                end
                default: begin
                    if (w_rd)  wcnt_q <= wcnt_q + WCW'(1);
                    if (if_rd) acnt_q <= acnt_q + AW'(1);
                end
            endcase
            // Tile index advances only on the switch between tiles.
            if ((state_q == S_STREAM || state_q == S_WAIT_W) && state_d == S_SWITCH)
                k_q <= k_q + KW'(1);
            dcnt_q <= (state_q == S_DRAIN) ? dcnt_q + DCW'(1) : '0;
        end
    end

    assign bus.inst_ready     = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.w_buffer_read  = w_rd;
    assign bus.if_buffer_read = if_rd;
    assign bus.switch         = sw;
    assign bus.first          = fst;
    assign bus.last           = lst;
    assign bus.done           = dn;
    assign bus.k_idx          = k_q;
    assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: a work-count model (weights loaded, rows
// streamed, switches made) predicts every output each cycle, and directed
// runs pin the event timing to hand-computed cycle numbers.
module tb_tile_sequencer;
  localparam int R    = 8;
  localparam int DRN  = 15;
  localparam int MAXA = 64;
  localparam int MAXK = 16;
  localparam int AW   = $clog2(MAXA + 1);
  localparam int KTW  = $clog2(MAXK + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   tcyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  tile_sequencer_if #(.MAX_A_ROWS(MAXA), .MAX_KTILES(MAXK)) bus ();

  tile_sequencer #(
    .SYS_ROWS(R), .SYS_COLS(8), .MAX_A_ROWS(MAXA), .MAX_KTILES(MAXK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];  // expected switch cycles (relative to acceptance)

  int avail_mode = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int done_tcyc = 0;
  int st_done, st_w, st_if, st_sw, st_fmin, st_fmax, st_lmin, st_lmax, st_klast;

  // model: work done so far for the current instruction
  int m_act = 0, m_zero = 0, m_kt = 0, m_a = 0;
  int m_wl = 0, m_rows = 0, m_sw = 0, m_drn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- avail driver ----------------
  initial begin
    int rel;
    bus.w_avail  = 1'b1;
    bus.if_avail = 1'b1;
    forever begin
      @(posedge clk); #1;
      rel = tcyc - acc_cyc;
      case (avail_mode)
        0: begin bus.w_avail = 1'b1; bus.if_avail = 1'b1; end
        1: begin
          bus.w_avail  = ($urandom_range(0, 3) != 0);
          bus.if_avail = ($urandom_range(0, 3) != 0);
        end
        default: begin
          bus.w_avail  = !(rel == 3 || rel == 4);
          bus.if_avail = !(rel >= 15 && rel <= 17);
        end
      endcase
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : cmp
    int wa, ia, e_wr, e_ir, e_sw, e_f, e_l, e_dn, e_k, wlim, rel;
    bit drain, sw_now, strm;
    wa = int'(bus.w_avail);
    ia = int'(bus.if_avail);
    e_wr = 0; e_ir = 0; e_sw = 0; e_f = 0; e_l = 0; e_dn = 0; e_k = 0;
    drain = 0; sw_now = 0; strm = 0;
    if (m_act != 0) begin
      if (m_zero != 0) e_dn = 1;
      else begin
        drain  = (m_sw == m_kt) && (m_rows == m_a * m_kt);
        sw_now = !drain && (m_wl == R * (m_sw + 1)) && (m_rows == m_a * m_sw);
        wlim   = imin(R * (m_sw + 1), R * m_kt);
        e_wr   = (!sw_now && !drain && m_wl < wlim && wa != 0) ? 1 : 0;
        strm   = (m_sw >= 1) && (m_rows < m_a * m_sw);
        e_ir   = (strm && ia != 0) ? 1 : 0;
        e_f    = (strm && m_sw == 1) ? 1 : 0;
        e_l    = (strm && m_sw == m_kt) ? 1 : 0;
        e_sw   = sw_now ? 1 : 0;
        e_k    = sw_now ? m_sw : ((m_sw > 0) ? m_sw - 1 : 0);
        e_dn   = (drain && m_drn == DRN) ? 1 : 0;
      end
    end

    if (tcyc >= 2) begin
      rel = tcyc - acc_cyc;
      check("inst_ready", 32'(bus.inst_ready), (m_act == 0) ? 1 : 0);
      check("busy", 32'(bus.busy), (m_act != 0) ? 1 : 0);
      check("done", 32'(bus.done), e_dn);
      check("switch", 32'(bus.switch), e_sw);
      check("w_buffer_read", 32'(bus.w_buffer_read), e_wr);
      check("if_buffer_read", 32'(bus.if_buffer_read), e_ir);
      check("first", 32'(bus.first), e_f);
      check("last", 32'(bus.last), e_l);
      if (m_act != 0) check("k_idx", 32'(bus.k_idx), e_k);
      if (bus.w_buffer_read) st_w++;
      if (bus.if_buffer_read) st_if++;
      if (bus.switch) begin
        st_sw++;
        if (exp_q.size() > 0) check("switch_at", rel, 32'(exp_q.pop_front()));
      end
      if (bus.first) begin st_fmin = imin(st_fmin, rel); if (rel > st_fmax) st_fmax = rel; end
      if (bus.last) begin st_lmin = imin(st_lmin, rel); if (rel > st_lmax) st_lmax = rel; end
      if (bus.if_buffer_read && bus.last) st_klast = int'(bus.k_idx);
      if (bus.done) begin st_done = rel; done_cnt++; done_tcyc = tcyc; end
    end

    // advance the model across the coming edge
    if (rst) begin
      m_act = 0; m_zero = 0; m_wl = 0; m_rows = 0; m_sw = 0; m_drn = 0;
    end else if (m_act == 0) begin
      if (bus.inst_valid) begin
        m_act  = 1;
        m_a    = imin(int'(bus.inst_a_rows), MAXA);
        m_kt   = imin(int'(bus.inst_ktiles), MAXK);
        m_zero = (m_a == 0 || m_kt == 0) ? 1 : 0;
        m_wl = 0; m_rows = 0; m_sw = 0; m_drn = 0;
        acc_cyc = tcyc;
        st_done = -1; st_w = 0; st_if = 0; st_sw = 0; st_klast = -1;
        st_fmin = 99999; st_fmax = -1; st_lmin = 99999; st_lmax = -1;
      end
    end else if (m_zero != 0 || e_dn != 0) begin
      m_act = 0;
    end else begin
      m_wl   += e_wr;
      m_rows += e_ir;
      if (sw_now) m_sw++;
      if (drain) m_drn++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_inst(input int a, input int kt);
    int n;
    n = 0;
    while (!bus.inst_ready && n < 1000) begin @(posedge clk); #1; n++; end
    check("ready_seen", 32'(bus.inst_ready), 1);
    bus.inst_valid  = 1'b1;
    bus.inst_a_rows = AW'(a);
    bus.inst_ktiles = KTW'(kt);
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
  endtask

  task automatic run_inst(input int a, input int kt, input int mode, input int budget);
    int n, d0;
    avail_mode = mode;
    start_inst(a, kt);
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); #1; n++; end
    check("done_seen", done_cnt - d0, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, n, prev_done;
    rst = 1'b1;
    bus.inst_valid  = 1'b0;
    bus.inst_a_rows = '0;
    bus.inst_ktiles = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_inst_ready", 32'(bus.inst_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_reads", 32'({bus.w_buffer_read, bus.if_buffer_read}), 0);
    check("rst_k_idx", 32'(bus.k_idx), 0);

    // one tile, 16 rows
    exp_q.push_back(16'd9);
    run_inst(16, 1, 0, 200);
    check("t1_done_at", st_done, 41);
    check("t1_w_reads", st_w, 8);
    check("t1_if_reads", st_if, 16);
    check("t1_first_lo", st_fmin, 10);
    check("t1_first_hi", st_fmax, 25);
    check("t1_last_hi", st_lmax, 25);
    check("t1_switch_left", exp_q.size(), 0);

    // two tiles, full overlap
    exp_q.push_back(16'd9); exp_q.push_back(16'd26);
    run_inst(16, 2, 0, 200);
    check("t2_done_at", st_done, 58);
    check("t2_w_reads", st_w, 16);
    check("t2_first_lo", st_fmin, 10);
    check("t2_first_hi", st_fmax, 25);
    check("t2_last_lo", st_lmin, 27);
    check("t2_last_hi", st_lmax, 42);
    check("t2_switch_left", exp_q.size(), 0);

    // two short tiles: stall for the shadow load
    exp_q.push_back(16'd9); exp_q.push_back(16'd18);
    run_inst(4, 2, 0, 200);
    check("t3_done_at", st_done, 38);
    check("t3_if_reads", st_if, 8);
    check("t3_k_last", st_klast, 1);
    check("t3_switch_left", exp_q.size(), 0);

    // stalls: 2 weight cycles in preload, 3 input cycles mid-stream
    exp_q.push_back(16'd11);
    run_inst(16, 1, 2, 200);
    check("stall_done_at", st_done, 46);
    check("stall_w_reads", st_w, 8);
    check("stall_if_reads", st_if, 16);
    check("stall_switch_left", exp_q.size(), 0);

    // zero-length instructions back to back
    run_inst(0, 3, 0, 50);
    check("zk_done_at", st_done, 1);
    check("zk_reads", st_w + st_if, 0);
    prev_done = done_tcyc;
    run_inst(5, 0, 0, 50);
    check("b2b_accept", acc_cyc, prev_done + 1);
    check("za_done_at", st_done, 1);
    check("za_reads", st_w + st_if, 0);

    // reset during tile 1 streaming
    avail_mode = 0;
    start_inst(16, 2);
    n = 0;
    while ((tcyc - acc_cyc) < 30 && n < 200) begin @(posedge clk); #1; n++; end
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 32'(bus.inst_ready), 1);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_outs", 32'({bus.w_buffer_read, bus.if_buffer_read, bus.switch,
                             bus.first, bus.last, bus.done}), 0);
    check("abort_k_idx", 32'(bus.k_idx), 0);
    repeat (60) @(posedge clk);
    #1 check("abort_no_done", done_cnt - d0, 0);
    run_inst(16, 1, 0, 200);
    check("after_abort_done_at", st_done, 41);

    // saturation of oversize fields
    run_inst(100, 1, 1, 1000);
    check("sat_a_rows", st_if, 64);
    run_inst(3, 20, 0, 2000);
    check("sat_ktiles_w", st_w, 128);
    check("sat_ktiles_sw", st_sw, 16);

    // random instructions with random buffer availability
    for (int i = 0; i < 12; i++) begin
      int a, kt;
      a  = $urandom_range(0, 20);
      kt = $urandom_range(0, 4);
      run_inst(a, kt, 1, 3000);
      check("rand_w_reads", st_w, (a == 0) ? 0 : R * kt);
      check("rand_if_reads", st_if, (kt == 0) ? 0 : a * kt);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
